axil_quantum_rr_arbiter: RTL and testbench
==========================================

// Module: axil_quantum_rr_arbiter
// PURPOSE
//  Quantum-based round-robin arbiter for the AXI-Lite interconnect master side.
//  Consumes the DLock_timer tick and drives its start_i: the owner keeps the bus
//  for one quantum, then ownership rotates. A transaction in flight is never cut
//  off. Sits between the master request decoders and the slave-side address mux.
// PARAMETERS
//  NUM_MASTERS  4  number of requesting masters (>=2)
//  ID_W         $clog2(NUM_MASTERS)  width of grant_id_o (localparam)
// PORTS
//  clk_i          in   1            system clock
//  resetn_i       in   1            async active-low reset
//  req_i          in   NUM_MASTERS  per-master request (level, held until served)
//  txn_start_i    in   1            owner AW/AR handshake completed this cycle
//  txn_done_i     in   1            owner B/R handshake completed this cycle
//  tick_timer_i   in   1            quantum expiry pulse from DLock_timer
//  timer_start_o  out  1            to DLock_timer start_i; high while a grant is held
//  grant_o        out  NUM_MASTERS  one-hot grant, registered
//  grant_id_o     out  ID_W         binary index of owner (valid when grant_valid_o)
//  grant_valid_o  out  1            any grant active (= |grant_o)
//  expired_o      out  1            quantum expired while transaction outstanding
// BEHAVIOUR
//  Reset: async on resetn_i low. State=IDLE, grant_o=0, grant_id_o=0,
//   grant_valid_o=0, timer_start_o=0, expired_o=0, last_owner=NUM_MASTERS-1.
//  States: IDLE, OWN (granted, no txn outstanding), BUSY (txn outstanding), REL.
//  IDLE: if |req_i, pick first set req scanning from last_owner+1 (wrap mod N);
//   grant_o/grant_id_o registered -> OWN. Latency req->grant: 1 clock.
//  OWN: timer_start_o=1.
//   txn_start_i -> BUSY (takes priority over tick/req drop in same cycle).
//   else req_i[owner]=0 -> REL.
//   else tick_timer_i and any other req set -> REL.
//   else tick_timer_i, no other req -> stay OWN (quantum renewed, timer runs on).
//  BUSY: timer_start_o=1. tick_timer_i sets expired_o (sticky until leaving BUSY).
//   txn_done_i: if (expired_o or tick_timer_i same cycle) and other req set -> REL;
//   else -> OWN, expired_o cleared. txn_start_i ignored in BUSY (one outstanding).
//  REL: exactly one cycle; grant_o=0, grant_valid_o=0, timer_start_o=0,
//   expired_o=0, last_owner<=owner. -> IDLE. Timer sees start_i low >=2 cycles,
//   so every new owner starts a fresh quantum.
//  Handover: release condition at edge k -> REL at k+1, IDLE at k+2, new grant
//   visible after edge k+3 (2 bubble cycles).
//  grant_o always one-hot or zero; grant_id_o holds last value when no grant.
//  txn_start_i/txn_done_i outside OWN/BUSY respectively: ignored.
//  Single requester: never rotates; ticks in OWN/BUSY with no other req ignored
//   (expired_o still flags in BUSY, cleared on done).
//  Reset mid-transaction: immediate return to reset values; no pending state kept.
// TESTING (bench pairs DUT with DLock_timer, QUANTUM_TIME=3, 10 ns clock)
//  1 Reset: resetn_i=0 20ns, req_i=4'b1111 -> all outputs 0; release -> grant_o=
//    4'b0001 one clock after first sampled edge, timer_start_o=1.
//  2 Rotation: req_i=4'b1011 held, no txns -> owner order 0,1,3,0; each owner
//    holds 3 cycles, REL+IDLE gap of 2 cycles, grant never 4'b0100.
//  3 Txn across tick: owner 0 txn_start_i at cycle 1, txn_done_i at cycle 6,
//    req_i=4'b0011 -> expired_o=1 after tick, grant_o stays 4'b0001 until done,
//    then REL, then grant_o=4'b0010.
//  4 Simultaneous: in BUSY assert txn_done_i and tick_timer_i same cycle with
//    req_i=4'b0101 -> REL next cycle, next grant 4'b0100.
//  5 Sole requester / drop: req_i=4'b1000 for 10 cycles -> grant held through
//    ticks; drop req_i[3] in OWN -> REL next cycle, then IDLE, grant_o=0.
//  6 Reset in BUSY: resetn_i low mid-txn -> outputs 0 asynchronously; after
//    release req_i=4'b0100 -> grant_o=4'b0100 (pointer restarted at 0).

Source files
------------

// File: rtl/axil_quantum_rr_arbiter.sv
// Quantum round-robin arbiter: owner keeps the bus for one timer quantum, then ownership rotates.
// Latency: req->grant 1 clock from IDLE; handover inserts REL+IDLE (2 bubble cycles).
// Backpressure: an outstanding transaction holds the grant past expiry until txn_done_i.
module axil_quantum_rr_arbiter #(
    parameter  int NUM_MASTERS = 4,
    localparam int ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   txn_start_i,
    input  logic                   txn_done_i,
    input  logic                   tick_timer_i,
    output logic                   timer_start_o,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [ID_W-1:0]        grant_id_o,
    output logic                   grant_valid_o,
    output logic                   expired_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        BUSY = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t                 state_q, state_nxt;
    logic [NUM_MASTERS-1:0] grant_q, grant_nxt;
    logic [ID_W-1:0]        grant_id_q, grant_id_nxt;
    logic [ID_W-1:0]        last_owner_q, last_owner_nxt;
    logic                   expired_q, expired_nxt;

    logic                   pick_vld;
    logic [ID_W-1:0]        pick_id;
    logic [ID_W-1:0]        cand;
    logic                   other_req;

    // Scan starts one past the previous owner so every requester is reached within N grants.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = ID_W'((int'(last_owner_q) + i) % NUM_MASTERS);
            if (!pick_vld && req_i[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign other_req = |(req_i & ~grant_q);

    always_comb begin
        state_nxt      = state_q;
        grant_nxt      = grant_q;
        grant_id_nxt   = grant_id_q;
        last_owner_nxt = last_owner_q;
        expired_nxt    = expired_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_id;
                    grant_id_nxt = pick_id;
                    state_nxt    = OWN;
                end
            end
            OWN: begin
                if (txn_start_i) begin
                    state_nxt = BUSY;
                end else if (!req_i[grant_id_q] || (tick_timer_i && other_req)) begin
                    grant_nxt = '0;
                    state_nxt = REL;
                end
            end
            BUSY: begin
                if (txn_done_i) begin
                    expired_nxt = 1'b0;
                    if ((expired_q || tick_timer_i) && other_req) begin
                        grant_nxt = '0;
                        state_nxt = REL;
                    end else begin
                        state_nxt = OWN;
                    end
                end else if (tick_timer_i) begin
                    expired_nxt = 1'b1;
                end
            end
            REL: begin
                // grant_id_q still names the departing owner here
                last_owner_nxt = grant_id_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            last_owner_q <= ID_W'(NUM_MASTERS - 1);
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            grant_q      <= grant_nxt;
            grant_id_q   <= grant_id_nxt;
            last_owner_q <= last_owner_nxt;
            expired_q    <= expired_nxt;
        end
    end

    assign timer_start_o = (state_q == OWN) || (state_q == BUSY);
    assign grant_o       = grant_q;
    assign grant_id_o    = grant_id_q;
    assign grant_valid_o = |grant_q;
    assign expired_o     = expired_q;

endmodule

// File: tb/tb_axil_quantum_rr_arbiter.sv
// Bench for axil_quantum_rr_arbiter with a behavioural quantum timer (3 cycles) and arbitration model.
// Latency: n/a (bench). Backpressure: n/a (bench).
// Directed scenarios with literal expectations; the model is compared on every falling edge.
module tb_axil_quantum_rr_arbiter;
    localparam int N = 4;
    localparam int Q = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         txn_start = 1'b0;
    logic         txn_done = 1'b0;
    logic         tick;
    logic         timer_start;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         grant_valid;
    logic         expired;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axil_quantum_rr_arbiter #(.NUM_MASTERS(N)) dut (
        .clk_i         (clk),
        .resetn_i      (rst_n),
        .req_i         (req),
        .txn_start_i   (txn_start),
        .txn_done_i    (txn_done),
        .tick_timer_i  (tick),
        .timer_start_o (timer_start),
        .grant_o       (grant),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid),
        .expired_o     (expired)
    );

    // Quantum timer: restarts whenever start is low, pulses on the Q-th cycle of start high.
    int tcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            tcnt <= 0;
        else if (!timer_start) tcnt <= 0;
        else                   tcnt <= (tcnt == Q - 1) ? 0 : tcnt + 1;
    end
    assign tick = timer_start && (tcnt == Q - 1);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        return (o < 0) ? '0 : (N'(1) << o);
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        logic [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            t = r >> ((last + k) % N);
            if (t[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Model: who owns the bus, whether a transaction is outstanding, and the post-release bubble.
    int           m_owner, m_id, m_last, m_gap;
    logic         m_busy, m_exp;
    logic [N-1:0] m_others;
    logic         m_owner_req;
    assign m_others    = req & ~onehot(m_owner);
    assign m_owner_req = (req & onehot(m_owner)) != '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1; m_id <= 0; m_last <= N - 1; m_gap <= 0;
            m_busy <= 1'b0; m_exp <= 1'b0;
        end else if (m_owner >= 0) begin
            if ((!m_busy && !txn_start && (!m_owner_req || (tick && m_others != '0))) ||
                (m_busy && txn_done && (m_exp || tick) && m_others != '0)) begin
                m_last <= m_owner; m_owner <= -1; m_busy <= 1'b0; m_exp <= 1'b0; m_gap <= 1;
            end else if (!m_busy && txn_start) begin
                m_busy <= 1'b1;
            end else if (m_busy && txn_done) begin
                m_busy <= 1'b0; m_exp <= 1'b0;
            end else if (m_busy && tick) begin
                m_exp <= 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap <= m_gap - 1;
        end else if (req != '0) begin
            m_owner <= rr_pick(m_last, req);
            m_id    <= rr_pick(m_last, req);
        end
    end

    always @(negedge clk) begin
        check("grant",       32'(grant),       32'(onehot(m_owner)));
        check("grant_id",    32'(grant_id),    32'(m_id));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("timer_start", 32'(timer_start), 32'(m_owner >= 0));
        check("expired",     32'(expired),     32'(m_exp));
    end

    task automatic do_reset(input logic [N-1:0] r);
        @(negedge clk);
        #2 rst_n = 1'b0;
        txn_start = 1'b0;
        txn_done  = 1'b0;
        req       = r;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int           order[$];
    int           runs[$];
    int           gaps[$];
    int           run_len, gap_len, seen_two;
    logic [N-1:0] prev;

    initial begin
        // Reset state with all masters requesting
        req = 4'b1111;
        #12;
        check("rst_grant",   32'(grant),       32'h0);
        check("rst_valid",   32'(grant_valid), 32'h0);
        check("rst_timer",   32'(timer_start), 32'h0);
        check("rst_expired", 32'(expired),     32'h0);
        check("rst_id",      32'(grant_id),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", 32'(grant),       32'h1);
        check("first_timer", 32'(timer_start), 32'h1);

        // Rotation over 4'b1011
        do_reset(4'b1011);
        prev = '0; run_len = 0; gap_len = 0; seen_two = 0;
        repeat (20) begin
            @(negedge clk);
            if (grant == 4'b0100) seen_two++;
            if (grant != '0) begin
                if (prev == '0) begin
                    order.push_back(int'(grant_id));
                    if (order.size() > 1) gaps.push_back(gap_len);
                    run_len = 0;
                end
                run_len++;
            end else begin
                if (prev != '0) runs.push_back(run_len);
                gap_len = (prev != '0) ? 1 : gap_len + 1;
            end
            prev = grant;
        end
        check("rot_count", 32'(order.size()), 32'd4);
        check("rot_o0", 32'(order[0]), 32'd0);
        check("rot_o1", 32'(order[1]), 32'd1);
        check("rot_o2", 32'(order[2]), 32'd3);
        check("rot_o3", 32'(order[3]), 32'd0);
        for (int i = 0; i < 4; i++) check("rot_hold", 32'(runs[i]), 32'd3);
        for (int i = 0; i < 3; i++) check("rot_gap", 32'(gaps[i]), 32'd2);
        check("rot_never_m2", 32'(seen_two), 32'd0);

        // Transaction spans a tick: expiry flagged, grant held until done
        do_reset(4'b0011);
        @(negedge clk); txn_start = 1'b1;
        @(negedge clk); txn_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("span_expired", 32'(expired), 32'h1);
        check("span_hold",    32'(grant),   32'h1);
        @(negedge clk);
        check("span_hold2",   32'(grant),   32'h1);
        @(negedge clk); txn_done = 1'b1;
        @(negedge clk); txn_done = 1'b0;
        check("span_rel",     32'(grant),   32'h0);
        check("span_rel_exp", 32'(expired), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("span_next",    32'(grant),   32'h2);

        // Done before any tick returns to OWN; the next tick then rotates
        do_reset(4'b0011);
        @(negedge clk); txn_start = 1'b1;
        @(negedge clk); txn_start = 1'b0; txn_done = 1'b1;
        @(negedge clk); txn_done = 1'b0;
        check("early_own",  32'(grant), 32'h1);
        check("early_tick", 32'(tick),  32'h1);
        @(negedge clk);
        check("early_rel",  32'(grant), 32'h0);

        // Done and tick in the same cycle
        do_reset(4'b0101);
        @(negedge clk); txn_start = 1'b1;
        @(negedge clk); txn_start = 1'b0;
        @(negedge clk); txn_done = 1'b1;
        check("sim_tick", 32'(tick), 32'h1);
        @(negedge clk); txn_done = 1'b0;
        check("sim_rel",     32'(grant),   32'h0);
        check("sim_rel_exp", 32'(expired), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("sim_next", 32'(grant), 32'h4);

        // Sole requester keeps the bus through ticks, then drops
        do_reset(4'b1000);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("sole_hold", 32'(grant), 32'h8);
            txn_start = (i == 2);
            txn_done  = (i == 7);
            if (i == 4) check("sole_expired", 32'(expired), 32'h1);
            if (i == 8) check("sole_exp_clr", 32'(expired), 32'h0);
        end
        @(negedge clk); req = '0;
        @(negedge clk);
        check("drop_rel",   32'(grant),       32'h0);
        check("drop_timer", 32'(timer_start), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("drop_idle",  32'(grant_valid), 32'h0);

        // Reset while a transaction is outstanding
        do_reset(4'b0011);
        @(negedge clk); txn_start = 1'b1;
        @(negedge clk); txn_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant",   32'(grant),       32'h0);
        check("arst_timer",   32'(timer_start), 32'h0);
        check("arst_valid",   32'(grant_valid), 32'h0);
        check("arst_expired", 32'(expired),     32'h0);
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("arst_next",    32'(grant),    32'h4);
        check("arst_next_id", 32'(grant_id), 32'h2);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
